// File: rtl/frame_text_pkg.sv
// frame_text_pkg: shared constants and enums for the frame text writer.
package frame_text_pkg;
    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam logic [4:0] CHAR_BLANK  = 5'd0;
    localparam logic [4:0] CHAR_DIGIT0 = 5'd1;
    typedef enum logic {OP_PRINT = 1'b0, OP_CLEAR = 1'b1} op_t;
    typedef enum logic [1:0] {IDLE, CONVERT, EMIT, CLEAR} state_t;
endpackage

// File: rtl/frame_text_writer_bin2bcd.sv
// bin2bcd_serial: serial double-dabble converter, one input bit per cycle.
module bin2bcd_serial #(
    parameter int VAL_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [VAL_W-1:0]      value,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);
    localparam int CW = $clog2(VAL_W + 1);
    logic [VAL_W-1:0]    r_bin;
    logic [DIGITS*4-1:0] r_bcd;
    logic [DIGITS*4-1:0] w_adj;
    logic [CW-1:0]       r_cnt;
    logic                r_done;
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++)
            w_adj[k*4 +: 4] = r_bcd[k*4 +: 4] >= 4'd5 ? r_bcd[k*4 +: 4] + 4'd3 : r_bcd[k*4 +: 4];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (start) begin
            r_bin  <= value;
            r_bcd  <= '0;
            r_cnt  <= CW'(VAL_W);
            r_done <= 1'b0;
        end else if (r_cnt != '0) begin
            r_bcd  <= {w_adj[DIGITS*4-2:0], r_bin[VAL_W-1]};
            r_bin  <= {r_bin[VAL_W-2:0], 1'b0};
            r_cnt  <= r_cnt - CW'(1);
            r_done <= r_cnt == CW'(1);
        end else begin
            r_done <= 1'b0;
        end
    end
    assign done = r_done;
    assign bcd  = r_bcd;
endmodule

// File: rtl/frame_text_writer.sv
// frame_text_writer: turns PRINT/CLEAR commands into one-cell-per-cycle
// character writes for the VGA frame buffer.
module frame_text_writer
    import frame_text_pkg::*;
#(
    parameter int VAL_W  = 16,
    parameter int DIGITS = 5,
    parameter int COLS   = frame_text_pkg::COLS,
    parameter int ROWS   = frame_text_pkg::ROWS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [5:0]       req_x,
    input  logic [5:0]       req_y,
    input  logic [VAL_W-1:0] req_value,
    output logic [5:0]       x,
    output logic [5:0]       y,
    output logic [4:0]       char,
    output logic             wen,
    output logic             busy
);
    localparam int IW = $clog2(DIGITS + 1);
    state_t              r_state;
    logic [5:0]          r_px, r_py, r_cx, r_cy, r_x, r_y;
    logic [4:0]          r_char;
    logic                r_wen, r_seen;
    logic [IW-1:0]       r_idx;
    logic [DIGITS*4-1:0] r_sh;
    logic                w_start, w_done, w_last, w_nz, w_wen;
    logic [DIGITS*4-1:0] w_bcd, w_src;
    logic [3:0]          w_d;
    logic [6:0]          w_col;
    logic [4:0]          w_char;

    assign w_start = r_state == IDLE && req_valid && op_t'(req_op) == OP_PRINT;

    bin2bcd_serial #(.VAL_W(VAL_W), .DIGITS(DIGITS)) u_bcd (
        .clk(clk), .reset(reset), .start(w_start), .value(req_value),
        .done(w_done), .bcd(w_bcd)
    );

    // The first digit comes straight from the converter; later ones from the shift copy.
    assign w_src  = r_state == CONVERT ? w_bcd : r_sh;
    assign w_d    = w_src[DIGITS*4-1 -: 4];
    assign w_last = r_idx == IW'(DIGITS - 1);
    assign w_nz   = w_d != 4'd0 || r_seen || w_last;
    assign w_char = w_nz ? {1'b0, w_d} + CHAR_DIGIT0 : CHAR_BLANK;
    assign w_col  = {1'b0, r_px} + 7'(r_idx);
    assign w_wen  = w_col < 7'(COLS) && r_py < 6'(ROWS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_px    <= '0;
            r_py    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_char  <= '0;
            r_wen   <= 1'b0;
            r_seen  <= 1'b0;
            r_idx   <= '0;
            r_sh    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wen <= 1'b0;
                    if (req_valid) begin
                        r_px    <= req_x;
                        r_py    <= req_y;
                        r_idx   <= '0;
                        r_seen  <= 1'b0;
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_state <= op_t'(req_op) == OP_CLEAR ? CLEAR : CONVERT;
                    end
                end
                CONVERT, EMIT: begin
                    if (r_state == EMIT && r_idx == IW'(DIGITS)) begin
                        r_wen   <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_state == EMIT || w_done) begin
                        r_x     <= w_col[5:0];
                        r_y     <= r_py;
                        r_char  <= w_char;
                        r_wen   <= w_wen;
                        r_sh    <= w_src << 4;
                        r_seen  <= w_nz;
                        r_idx   <= r_idx + IW'(1);
                        r_state <= EMIT;
                    end
                end
                CLEAR: begin
                    if (r_cy == 6'(ROWS)) begin
                        r_wen   <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_x    <= r_cx;
                        r_y    <= r_cy;
                        r_char <= CHAR_BLANK;
                        r_wen  <= 1'b1;
                        r_cx   <= r_cx == 6'(COLS - 1) ? 6'd0 : r_cx + 6'd1;
                        r_cy   <= r_cx == 6'(COLS - 1) ? r_cy + 6'd1 : r_cy;
                    end
                end
            endcase
        end
    end

    assign req_ready = r_state == IDLE;
    assign busy      = r_state != IDLE;
    assign x         = r_x;
    assign y         = r_y;
    assign char      = r_char;
    assign wen       = r_wen;
endmodule

// File: doc/frame_text_writer.md
Name: frame_text_writer

Overview:
- Upstream producer for the VGA character frame buffer. Converts host display commands into a stream of single-cell character writes on the `x`, `y`, `char`, `wen` interface that the frame stage consumes.
- Supports two commands:
  - Print an unsigned binary value as right-aligned, leading-blank decimal digits at a given cell.
  - Clear the whole 40x30 grid to blank.
- Sits between the trading-logic status/price registers and the frame stage; the frame stage never sees more than one write per clock.

Parameters:
- VAL_W, 16, width of the value to print.
- DIGITS, 5, decimal field width in characters; must hold the largest VAL_W value.
- COLS, 40, grid columns.
- ROWS, 30, grid rows.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  command present.
- req_ready  out  1  block can accept a command.
- req_op  in  1  0 = PRINT, 1 = CLEAR.
- req_x  in  6  leftmost column of the PRINT field.
- req_y  in  6  row of the PRINT field.
- req_value  in  VAL_W  unsigned value for PRINT.
- x  out  6  column of the current write.
- y  out  6  row of the current write.
- char  out  5  character code: 0 = blank, 1..10 = digits '0'..'9'.
- wen  out  1  write strobe, one cell per cycle.
- busy  out  1  command in progress (state != IDLE).

Behaviour:
- Reset:
  - State goes to IDLE.
  - `x`, `y`, `char` = 0; `wen` = 0; `busy` = 0.
  - Bin-to-BCD working registers are cleared.
  - `req_ready` = (state == IDLE), so it reads 1 during and after reset. Requests presented while reset is asserted are not accepted.
- Handshake: a command is accepted on a rising clk edge where `req_valid && req_ready`. The `req_*` fields are captured on that edge; later changes are ignored.
- State machine: IDLE, CONVERT, EMIT, CLEAR.
  - IDLE -> CONVERT on accepted PRINT.
  - IDLE -> CLEAR on accepted CLEAR.
  - CONVERT -> EMIT after exactly VAL_W cycles of serial double-dabble (shift-add-3), one bit per cycle.
  - EMIT -> IDLE after exactly DIGITS cycles.
  - CLEAR -> IDLE after exactly COLS*ROWS cycles.
- PRINT timing:
  - Call the acceptance edge edge 0.
  - Registered outputs present the first write after edge VAL_W+1 (edge 17 by default).
  - `wen` is high for DIGITS consecutive cycles.
  - `req_ready` returns to 1 after the last write.
  - Total occupancy is VAL_W+DIGITS+1 cycles from acceptance.
- PRINT output order: most significant digit first, `x` = req_x + i for i = 0..DIGITS-1, `y` = req_y.
- Character codes: digit d encodes as d+1.
- Leading-zero suppression:
  - Every digit more significant than the most significant nonzero digit is written as code 0 (blank).
  - Value 0 writes DIGITS-1 blanks followed by code 1.
- Column out of range: a digit position with column >= COLS consumes its cycle but drives `wen` = 0. No wrap to the next row.
  - Column arithmetic is 7-bit, so req_x=63 does not wrap.
- Row out of range: if req_y >= ROWS, the whole PRINT runs with identical timing and `wen` = 0 throughout.
- CLEAR:
  - Writes code 0 to every cell in row-major order: (0,0), (1,0) … (39,0), (0,1) … (39,29).
  - One write per cycle, `wen` continuously high for 1200 cycles.
  - The first write follows edge 1 after acceptance.
- After the last write, `wen` drops to 0 on the next edge. `x`, `y`, `char` hold their last values while idle.
- Reset mid-command: the command is aborted immediately and outputs go to their reset values. Cells already written stay written; no partial rollback.
- Back-to-back commands: a new command is accepted on the first edge at which the block is IDLE. There is no request queue; `req_valid` must be held until accepted.

Decomposition:
- Package `frame_text_pkg`:
  - COLS, ROWS constants.
  - CHAR_BLANK = 5'd0, CHAR_DIGIT0 = 5'd1.
  - `op_t` enum {OP_PRINT, OP_CLEAR}.
  - `state_t` enum {IDLE, CONVERT, EMIT, CLEAR}.
- Sub-module `bin2bcd_serial`:
  - Parameterised by VAL_W and DIGITS.
  - Ports: start, value in; done pulse and packed BCD out.
  - Takes exactly VAL_W cycles.
- The top level owns the FSM, the emit/clear counters and the output registers.

Test Plan:
- PRINT 1234 at (10,5):
  - Writes (10,5,0), (11,5,2), (12,5,3), (13,5,4), (14,5,5).
  - First `wen` follows edge 17; `req_ready` = 0 during edges 1..22.
- PRINT 0 at (0,0): writes codes 0,0,0,0,1 to columns 0..4 of row 0.
- PRINT 65535 at (37,2):
  - Writes (37,2,7), (38,2,6), (39,2,6).
  - The following 2 cycles have `wen` = 0; occupancy is still 22 cycles.
- PRINT 42 at (3,30): 22 cycles busy, zero writes observed.
- CLEAR:
  - Exactly 1200 writes, all code 0; first (0,0), 40th (39,0), last (39,29).
  - `wen` has no gaps; `req_ready` = 1 on the next cycle.
- Reset (0) asserted during the 3rd EMIT cycle of PRINT 99999-capped value 54321 at (0,0):
  - `wen` = 0 immediately; only (0,0,6) and (1,0,5) were written.
  - After release, `req_ready` = 1 and a new PRINT completes normally.
